// File: rtl/rng_word_reader.sv
`default_nettype none
// ============================================================================
//  Module   : rng_word_reader
//  Purpose  : Consumer end of the ring-oscillator/LHCA entropy path. Samples
//             the LHCA state word every clock, discards a warm-up window, runs
//             a repetition-count health test and buffers passing words in a
//             first-word-fall-through FIFO drained over valid/ready. A failed
//             health test latches a sticky fault that flushes and blocks
//             all output until cleared.
//  Ports    : clk          system clock
//             rst          asynchronous reset, active-high
//             en           sampling enable
//             state_i      LHCA state word (WIDTH)
//             rnd_o        FIFO head word (WIDTH)
//             rnd_valid_o  rnd_o holds a word
//             rnd_ready_i  consumer accepts the head word
//             fault_o      sticky health-test failure
//             clr_fault_i  clears the fault and returns to IDLE
//             level_o      FIFO occupancy ($clog2(DEPTH)+1 bits)
//  Revision : 1.0  initial release
// ============================================================================
module rng_word_reader #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4,
   parameter int REP_LIMIT = 4,
   parameter int WARMUP    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [WIDTH-1:0]         state_i,
   output logic [WIDTH-1:0]         rnd_o,
   output logic                     rnd_valid_o,
   input  logic                     rnd_ready_i,
   output logic                     fault_o,
   input  logic                     clr_fault_i,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_WW = $clog2(WARMUP + 1);
   localparam int c_RW = $clog2(REP_LIMIT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WARMUP = 2'd1,
      S_RUN    = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_WW-1:0]   r_warm_cnt;
   logic [c_WW-1:0]   w_warm_cnt_nxt;
   logic [WIDTH-1:0]  r_prev;
   logic [c_RW-1:0]   r_rep_cnt;
   logic [c_RW-1:0]   w_rep_nxt;
   logic              w_sampling;
   logic              w_trip;

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [c_AW:0]     r_wr_ptr;
   logic [c_AW:0]     r_rd_ptr;
   logic [c_AW:0]     w_level;
   logic              w_full;
   logic              w_push;
   logic              w_pop;

   // ------------------------------------------------------------------------
   // Repetition-count health test. The count saturates at REP_LIMIT so a
   // long run of repeats during warm-up trips on the first RUN sample that
   // still repeats.
   // ------------------------------------------------------------------------
   assign w_sampling = (r_state == S_WARMUP) || (r_state == S_RUN);

   always_comb begin
      w_rep_nxt = c_RW'(1);
      if (state_i == r_prev) begin
         if (r_rep_cnt == c_RW'(REP_LIMIT))
            w_rep_nxt = r_rep_cnt;
         else
            w_rep_nxt = r_rep_cnt + c_RW'(1);
      end
   end

   assign w_trip = (r_state == S_RUN) && (w_rep_nxt == c_RW'(REP_LIMIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev    <= '0;
         r_rep_cnt <= '0;
      end else if (w_sampling) begin
         r_prev    <= state_i;
         r_rep_cnt <= w_rep_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_warm_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_warm_cnt <= w_warm_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_warm_cnt_nxt = r_warm_cnt;
      case (r_state)
         S_IDLE: begin
            if (en) begin
               w_state_nxt    = S_WARMUP;
               w_warm_cnt_nxt = '0;
            end
         end
         S_WARMUP: begin
            w_warm_cnt_nxt = r_warm_cnt + c_WW'(1);
            if (!en)
               w_state_nxt = S_IDLE;
            else if (r_warm_cnt == c_WW'(WARMUP - 1))
               w_state_nxt = S_RUN;
         end
         S_RUN: begin
            // A health failure outranks a simultaneous drop of en so the
            // fault can never be missed.
            if (w_trip)
               w_state_nxt = S_FAULT;
            else if (!en)
               w_state_nxt = S_IDLE;
         end
         S_FAULT: begin
            if (clr_fault_i)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FIFO: pointers carry one extra wrap bit so full and empty are distinct.
   // ------------------------------------------------------------------------
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_pop   = rnd_valid_o && rnd_ready_i;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push  = (r_state == S_RUN) && en && !w_trip && (!w_full || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (w_trip) begin
         // Entering FAULT discards everything already buffered.
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= state_i;
            r_wr_ptr                  <= r_wr_ptr + 1'b1;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   assign rnd_o       = r_mem[r_rd_ptr[c_AW-1:0]];
   assign rnd_valid_o = (w_level != '0) && (r_state != S_FAULT);
   assign fault_o     = (r_state == S_FAULT);
   assign level_o     = w_level;

endmodule
`default_nettype wire

// File: tb/tb_rng_word_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rng_word_reader
//  Purpose  : Directed self-checking bench for rng_word_reader: reset,
//             warm-up latency, backpressure, pointer wrap at full with
//             simultaneous push/pop, sub-threshold repeats, health fault and
//             clear, asynchronous reset mid-operation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rng_word_reader;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] state_i;
   logic [31:0] rnd_o;
   logic        rnd_valid_o;
   logic        rnd_ready_i;
   logic        fault_o;
   logic        clr_fault_i;
   logic [2:0]  level_o;

   int n_vec;
   int n_err;

   rng_word_reader #(
      .WIDTH     (32),
      .DEPTH     (4),
      .REP_LIMIT (4),
      .WARMUP    (16)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .state_i     (state_i),
      .rnd_o       (rnd_o),
      .rnd_valid_o (rnd_valid_o),
      .rnd_ready_i (rnd_ready_i),
      .fault_o     (fault_o),
      .clr_fault_i (clr_fault_i),
      .level_o     (level_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs set afterwards are seen at the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // en sampled in IDLE, then WARMUP samples base..base+15 that must never
   // appear at the output.
   task automatic do_warmup(input int base);
      en = 1'b1;
      tick();
      for (int k = 0; k < 16; k++) begin
         state_i = 32'(base + k);
         tick();
         check("warm_no_push", {31'd0, rnd_valid_o}, 32'd0);
      end
   endtask

   logic [31:0] exp_w;
   logic [31:0] t5_vals [4];

   initial begin
      n_vec       = 0;
      n_err       = 0;
      rst         = 1'b1;
      en          = 1'b0;
      state_i     = '0;
      rnd_ready_i = 1'b0;
      clr_fault_i = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // ---- reset state ----
      check("rst_level", {29'd0, level_o}, 32'd0);
      check("rst_valid", {31'd0, rnd_valid_o}, 32'd0);
      check("rst_fault", {31'd0, fault_o}, 32'd0);
      check("rst_rnd",   rnd_o, 32'd0);

      // ---- warm-up: values 0..15 discarded, first word is 16 ----
      rnd_ready_i = 1'b1;
      do_warmup(0);
      for (int k = 16; k < 20; k++) begin
         state_i = 32'(k);
         tick();
         check("run_rnd",   rnd_o, 32'(k));
         check("run_valid", {31'd0, rnd_valid_o}, 32'd1);
         check("run_level", {29'd0, level_o}, 32'd1);
      end

      // ---- backpressure: head 19, push 20..22, drop 23..24 ----
      rnd_ready_i = 1'b0;
      for (int k = 20; k < 25; k++) begin
         state_i = 32'(k);
         tick();
         check("bp_hold", rnd_o, 32'd19);
      end
      check("bp_level", {29'd0, level_o}, 32'd4);

      // ---- drain at full with push+pop, 20 words across pointer wrap ----
      // Accepted order: 19,20,21,22 then 25,26,... (23,24 were dropped).
      rnd_ready_i = 1'b1;
      for (int j = 0; j < 20; j++) begin
         exp_w = (j < 4) ? 32'(19 + j) : 32'(21 + j);
         check("full_order", rnd_o, exp_w);
         check("full_level", {29'd0, level_o}, 32'd4);
         state_i = 32'(25 + j);
         tick();
      end

      // ---- drop en: FIFO holds 41..44 and stays poppable in IDLE ----
      en      = 1'b0;
      state_i = 32'd45;
      for (int i = 0; i < 4; i++) begin
         check("idle_pop", rnd_o, 32'(41 + i));
         tick();
      end
      check("idle_empty_valid", {31'd0, rnd_valid_o}, 32'd0);
      check("idle_empty_level", {29'd0, level_o}, 32'd0);

      // ---- sub-threshold repeats: 3x 55 then 66, all four pushed ----
      rnd_ready_i = 1'b0;
      do_warmup(100);
      t5_vals[0] = 32'h55; t5_vals[1] = 32'h55;
      t5_vals[2] = 32'h55; t5_vals[3] = 32'h66;
      for (int i = 0; i < 4; i++) begin
         state_i = t5_vals[i];
         tick();
         check("rep_level", {29'd0, level_o}, 32'(i + 1));
         check("rep_fault", {31'd0, fault_o}, 32'd0);
      end
      en          = 1'b0;
      rnd_ready_i = 1'b1;
      state_i     = 32'h77;
      for (int i = 0; i < 4; i++) begin
         check("rep_order", rnd_o, t5_vals[i]);
         tick();
      end
      check("rep_drained", {31'd0, rnd_valid_o}, 32'd0);

      // ---- health fault: 4th identical DEADBEEF trips ----
      rnd_ready_i = 1'b0;
      do_warmup(200);
      state_i = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hf_level", {29'd0, level_o}, 32'(i + 1));
         check("hf_nofault", {31'd0, fault_o}, 32'd0);
      end
      check("hf_head", rnd_o, 32'hDEADBEEF);
      tick();
      check("hf_fault", {31'd0, fault_o}, 32'd1);
      check("hf_valid", {31'd0, rnd_valid_o}, 32'd0);
      check("hf_flush", {29'd0, level_o}, 32'd0);
      rnd_ready_i = 1'b1;
      state_i     = 32'd1;
      repeat (2) tick();
      check("hf_sticky", {31'd0, fault_o}, 32'd1);
      check("hf_blocked", {29'd0, level_o}, 32'd0);
      en          = 1'b0;
      clr_fault_i = 1'b1;
      tick();
      clr_fault_i = 1'b0;
      check("clr_fault", {31'd0, fault_o}, 32'd0);
      check("clr_valid", {31'd0, rnd_valid_o}, 32'd0);

      // ---- async reset mid-RUN with level 3 ----
      rnd_ready_i = 1'b0;
      do_warmup(300);
      for (int k = 400; k < 403; k++) begin
         state_i = 32'(k);
         tick();
      end
      check("pre_rst_level", {29'd0, level_o}, 32'd3);
      rst = 1'b1;
      #2;
      check("arst_level", {29'd0, level_o}, 32'd0);
      check("arst_valid", {31'd0, rnd_valid_o}, 32'd0);
      check("arst_fault", {31'd0, fault_o}, 32'd0);
      check("arst_rnd",   rnd_o, 32'd0);
      en = 1'b0;
      tick();
      rst = 1'b0;
      // Back in IDLE: a full warm-up must precede the next push.
      do_warmup(600);
      state_i = 32'd700;
      tick();
      check("post_rst_level", {29'd0, level_o}, 32'd1);
      check("post_rst_rnd",   rnd_o, 32'd700);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
